// File: rtl/rle_pkg.sv
// -----------------------------------------------------------------------------
// rle_pkg
//   Shared types and default widths for the run-length encoder controller.
//   - DATA_W_DEF / LEN_W_DEF : default sample width and run-length field width
//   - rle_state_e            : controller FSM states
//   - rc_op_e                : operation the controller requests from the
//                              run_counter datapath each cycle
// -----------------------------------------------------------------------------
package rle_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    // IDLE      : no open run
    // RUN       : open run held in cur_val/cur_len
    // EMIT      : record presented, a new beat is pending behind it
    // EMIT_LAST : final record of the stream presented
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EMIT      = 2'd2,
        EMIT_LAST = 2'd3
    } rle_state_e;

    typedef enum logic [2:0] {
        RC_HOLD    = 3'd0,  // keep everything
        RC_LOAD    = 3'd1,  // open a new run from the input beat
        RC_INC     = 3'd2,  // extend the open run by one
        RC_PEND    = 3'd3,  // park the input beat as pending
        RC_PROMOTE = 3'd4   // pending beat becomes the open run
    } rc_op_e;

endpackage

// File: rtl/rle_ctrl_if.sv
// -----------------------------------------------------------------------------
// rle_ctrl_if
//   Sample-in / record-out handshake bundle of rle_ctrl.
//   Input side : in_valid, in_val, in_last  (producer -> block), in_ready back
//   Output side: out_valid, out_val, out_len, out_last (block -> consumer),
//                out_ready back
//   modport master : the environment (producer + consumer)
//   modport slave  : the rle_ctrl block
// -----------------------------------------------------------------------------
interface rle_ctrl_if #(
    parameter int DATA_W = rle_pkg::DATA_W_DEF,
    parameter int LEN_W  = rle_pkg::LEN_W_DEF
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_val;
    logic              in_last;
    logic              in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_val;
    logic [LEN_W-1:0]  out_len;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_val, in_last, out_ready,
        input  in_ready, out_valid, out_val, out_len, out_last
    );

    modport slave (
        input  in_valid, in_val, in_last, out_ready,
        output in_ready, out_valid, out_val, out_len, out_last
    );

endinterface

// File: rtl/rle_ctrl_run_counter.sv
// -----------------------------------------------------------------------------
// run_counter
//   Run-length datapath: holds the open run (cur_val/cur_len) and one pending
//   beat (value + last flag; its length is implicitly 1).
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     op          : operation requested by the controller this cycle
//     in_val      : incoming sample value
//     in_last     : incoming beat is the last of the stream
//     can_extend  : in_val equals the open run value and the run is not full
//     cur_val     : value of the open run
//     cur_len     : length of the open run (saturates at RUN_MAX)
//     pend_last   : last flag of the pending beat
// -----------------------------------------------------------------------------
module run_counter
    import rle_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  rc_op_e            op,
    input  logic [DATA_W-1:0] in_val,
    input  logic              in_last,
    output logic              can_extend,
    output logic [DATA_W-1:0] cur_val,
    output logic [LEN_W-1:0]  cur_len,
    output logic              pend_last
);

    localparam logic [LEN_W-1:0] RUN_MAX = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [DATA_W-1:0] cur_val_q,  cur_val_d;
    logic [LEN_W-1:0]  cur_len_q,  cur_len_d;
    logic [DATA_W-1:0] pend_val_q, pend_val_d;
    logic              pend_last_q, pend_last_d;

    // A full run must close even if the value repeats, so the run splits
    // instead of wrapping.
    assign can_extend = (in_val == cur_val_q) && (cur_len_q != RUN_MAX);

    always_comb begin
        // NOTE: every variable gets its hold value before the case, so no
        // branch can leave it unassigned and infer a latch.
        cur_val_d   = cur_val_q;
        cur_len_d   = cur_len_q;
        pend_val_d  = pend_val_q;
        pend_last_d = pend_last_q;
        unique case (op)
            RC_LOAD: begin
                cur_val_d = in_val;
                cur_len_d = LEN_ONE;
            end
            RC_INC: begin
                cur_len_d = (cur_len_q == RUN_MAX) ? cur_len_q : cur_len_q + LEN_ONE;
            end
            RC_PEND: begin
                pend_val_d  = in_val;
                pend_last_d = in_last;
            end
            RC_PROMOTE: begin
                cur_val_d   = pend_val_q;
                cur_len_d   = LEN_ONE;
                pend_val_d  = '0;
                pend_last_d = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_val_q   <= '0;
            cur_len_q   <= '0;
            pend_val_q  <= '0;
            pend_last_q <= 1'b0;
        end else begin
            cur_val_q   <= cur_val_d;
            cur_len_q   <= cur_len_d;
            pend_val_q  <= pend_val_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign cur_val   = cur_val_q;
    assign cur_len   = cur_len_q;
    assign pend_last = pend_last_q;

endmodule

// File: rtl/rle_ctrl.sv
// -----------------------------------------------------------------------------
// rle_ctrl
//   Run-length encoder controller. Accepts a stream of samples and produces
//   (value, length, last) records, one per maximal run of equal samples; runs
//   longer than 2^LEN_W-1 are split.
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous active-high reset; drops any open run or pending beat
//     bus  : rle_ctrl_if slave modport (in_* handshake in, out_* records out)
//   Records are presented only in EMIT / EMIT_LAST and are driven straight from
//   held registers, so they stay stable until out_ready takes them.
// -----------------------------------------------------------------------------
module rle_ctrl
    import rle_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    rle_ctrl_if.slave   bus
);

    rle_state_e        state_q, state_d;
    rc_op_e            rc_op;

    logic              can_extend;
    logic [DATA_W-1:0] cur_val;
    logic [LEN_W-1:0]  cur_len;
    logic              pend_last;

    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;

    run_counter #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_run_counter (
        .clk        (clk),
        .rst        (rst),
        .op         (rc_op),
        .in_val     (bus.in_val),
        .in_last    (bus.in_last),
        .can_extend (can_extend),
        .cur_val    (cur_val),
        .cur_len    (cur_len),
        .pend_last  (pend_last)
    );

    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the datapath operation that goes with each transition
    always_comb begin
        state_d = state_q;
        rc_op   = RC_HOLD;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    rc_op   = RC_LOAD;
                    state_d = bus.in_last ? EMIT_LAST : RUN;
                end
            end
            RUN: begin
                if (in_fire) begin
                    if (can_extend) begin
                        rc_op   = RC_INC;
                        state_d = bus.in_last ? EMIT_LAST : RUN;
                    end else begin
                        // Close the open run; the new beat waits behind it.
                        rc_op   = RC_PEND;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    rc_op   = RC_PROMOTE;
                    state_d = pend_last ? EMIT_LAST : RUN;
                end
            end
            EMIT_LAST: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state only
    always_comb begin
        in_ready     = (state_q == IDLE) || (state_q == RUN);
        out_valid    = (state_q == EMIT) || (state_q == EMIT_LAST);
        bus.out_val  = out_valid ? cur_val : '0;
        bus.out_len  = out_valid ? cur_len : '0;
        bus.out_last = (state_q == EMIT_LAST);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_rle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rle_ctrl
//   Self-checking bench for rle_ctrl. Two instances share one stimulus driver:
//   dut8 (LEN_W=8) and dut2 (LEN_W=2); 'sel' chooses which one is active while
//   the other idles. Expected records come from a reference model that splits
//   the beat list into maximal equal runs and chops each run into RUN_MAX-sized
//   pieces.
// -----------------------------------------------------------------------------
module tb_rle_ctrl;
    import rle_pkg::*;

    typedef struct packed {
        logic [7:0] val;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [7:0] val;
        logic [7:0] len;
        logic       last;
    } rec_t;

    typedef beat_t beat_q_t[$];
    typedef rec_t  rec_q_t[$];

    typedef struct {
        bit       iv;
        bit [7:0] ival;
        bit       ilast;
        bit       ordy;
        bit       e_ir;
        bit       e_ov;
        bit [7:0] e_val;
        bit [7:0] e_len;
        bit       e_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       in_valid;
    logic [7:0] in_val;
    logic       in_last;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rle_ctrl_if #(.DATA_W(8), .LEN_W(8)) bus8 ();
    rle_ctrl_if #(.DATA_W(8), .LEN_W(2)) bus2 ();

    rle_ctrl #(.DATA_W(8), .LEN_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    rle_ctrl #(.DATA_W(8), .LEN_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus8.in_valid  = in_valid && !sel;
    assign bus8.in_val    = in_val;
    assign bus8.in_last   = in_last;
    assign bus8.out_ready = sel ? 1'b1 : out_ready;
    assign bus2.in_valid  = in_valid && sel;
    assign bus2.in_val    = in_val;
    assign bus2.in_last   = in_last;
    assign bus2.out_ready = sel ? out_ready : 1'b1;

    logic       o_in_ready, o_out_valid, o_out_last;
    logic [7:0] o_out_val, o_out_len;
    assign o_in_ready  = sel ? bus2.in_ready  : bus8.in_ready;
    assign o_out_valid = sel ? bus2.out_valid : bus8.out_valid;
    assign o_out_val   = sel ? bus2.out_val   : bus8.out_val;
    assign o_out_len   = sel ? {6'b0, bus2.out_len} : bus8.out_len;
    assign o_out_last  = sel ? bus2.out_last  : bus8.out_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [7:0] v, input bit lst, input bit rdy);
        in_valid  = iv;
        in_val    = v;
        in_last   = lst;
        out_ready = rdy;
    endtask

    task automatic check_out(input string tag, input bit ir, input bit ov,
                             input logic [7:0] v, input logic [7:0] l, input bit lst);
        check({tag, " in_ready"}, 32'(o_in_ready), 32'(ir));
        check({tag, " out_valid"}, 32'(o_out_valid), 32'(ov));
        if (ov)
            check({tag, " record"}, 32'({o_out_val, o_out_len, o_out_last}), 32'({v, l, lst}));
    endtask

    // Reference: maximal runs of equal values, each chopped into RUN_MAX pieces.
    function automatic rec_q_t model(input beat_q_t beats, input int run_max);
        rec_q_t recs;
        int i = 0;
        int n = beats.size();
        while (i < n) begin
            int j = i;
            int remaining;
            while (j + 1 < n && beats[j+1].val == beats[i].val) j++;
            remaining = j - i + 1;
            while (remaining > 0) begin
                int chunk = (remaining > run_max) ? run_max : remaining;
                remaining -= chunk;
                recs.push_back(rec_t'{val: beats[i].val, len: 8'(chunk),
                                      last: (j == n - 1) && (remaining == 0)});
            end
            i = j + 1;
        end
        return recs;
    endfunction

    // Streams beats with random gaps and back-pressure, comparing every
    // transferred record against exp and checking stalled records stay put.
    task automatic run_stream(input beat_q_t beats, input rec_q_t exp,
                              input int gap_pct, input int rdy_pct, input string tag);
        int   bi = 0;
        int   ri = 0;
        int   cyc = 0;
        bit   hold = 1'b0;
        rec_t held = '0;
        rec_t cur;
        while (ri < exp.size() && cyc < 3000) begin
            in_valid  = (bi < beats.size()) && ($urandom_range(0, 99) >= gap_pct);
            in_val    = (bi < beats.size()) ? beats[bi].val : 8'h00;
            in_last   = (bi < beats.size()) ? beats[bi].last : 1'b0;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            cur = '{val: o_out_val, len: o_out_len, last: o_out_last};
            if (hold)
                check({tag, " stall stable"}, 32'({o_out_valid, cur}), 32'({1'b1, held}));
            if (o_out_valid && out_ready) begin
                check($sformatf("%s rec%0d", tag, ri), 32'(cur), 32'(exp[ri]));
                ri++;
            end
            hold = o_out_valid && !out_ready;
            held = cur;
            if (in_valid && o_in_ready) bi++;
            step();
            cyc++;
        end
        check({tag, " record count"}, ri, exp.size());
        check({tag, " beats taken"}, bi, beats.size());
        drive(0, 8'h00, 0, 1);
        step();
        check({tag, " idle after"}, 32'({o_in_ready, o_out_valid}), 32'({1'b1, 1'b0}));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[14];
        beat_q_t bq;
        rec_q_t  eq;

        // 5,5,5,7(last); single 0x2A(last) with a stall; 3,4(last) with a
        // beat offered while the block is not ready (must be ignored).
        tbl[0]  = '{1, 8'd5,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[1]  = '{1, 8'd5,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[2]  = '{1, 8'd5,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[3]  = '{1, 8'd7,   1, 1,  0, 1, 8'd5,   8'd3, 0};
        tbl[4]  = '{0, 8'd0,   0, 1,  0, 1, 8'd7,   8'd1, 1};
        tbl[5]  = '{0, 8'd0,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[6]  = '{1, 8'h2A,  1, 1,  0, 1, 8'h2A,  8'd1, 1};
        tbl[7]  = '{0, 8'd0,   0, 0,  0, 1, 8'h2A,  8'd1, 1};
        tbl[8]  = '{0, 8'd0,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[9]  = '{1, 8'd3,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[10] = '{1, 8'd4,   1, 1,  0, 1, 8'd3,   8'd1, 0};
        tbl[11] = '{1, 8'd9,   0, 1,  0, 1, 8'd4,   8'd1, 1};
        tbl[12] = '{1, 8'd9,   0, 1,  1, 0, 8'd0,   8'd0, 0};
        tbl[13] = '{0, 8'd0,   0, 1,  1, 0, 8'd0,   8'd0, 0};

        sel = 1'b0;
        drive(0, 8'h00, 0, 0);
        rst = 1'b1;
        step();
        step();
        check("reset outputs", 32'({o_in_ready, o_out_valid, o_out_val, o_out_len, o_out_last}),
              32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
        check("reset state", 32'(dut8.state_q), 32'(IDLE));
        rst = 1'b0;
        step();
        check_out("post reset", 1, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].iv, tbl[i].ival, tbl[i].ilast, tbl[i].ordy);
            step();
            check_out($sformatf("row%0d", i), tbl[i].e_ir, tbl[i].e_ov,
                      tbl[i].e_val, tbl[i].e_len, tbl[i].e_last);
        end
        check("state back to idle", 32'(dut8.state_q), 32'(IDLE));

        // Back-pressure: record (4,1) must hold for 5 stalled cycles.
        drive(1, 8'd4, 0, 1); step(); check_out("bp open", 1, 0, 0, 0, 0);
        drive(1, 8'd8, 1, 0); step(); check_out("bp emit", 0, 1, 8'd4, 8'd1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'd0, 0, 0);
            step();
            check_out($sformatf("bp stall%0d", i), 0, 1, 8'd4, 8'd1, 0);
        end
        drive(0, 8'd0, 0, 1); step(); check_out("bp last", 0, 1, 8'd8, 8'd1, 1);
        drive(0, 8'd0, 0, 1); step(); check_out("bp idle", 1, 0, 0, 0, 0);

        // Gaps of 3 idle cycles between equal beats keep one run open.
        for (int b = 0; b < 3; b++) begin
            drive(1, 8'd6, b == 2, 1);
            step();
            if (b < 2) begin
                check_out($sformatf("gap beat%0d", b), 1, 0, 0, 0, 0);
                for (int g = 0; g < 3; g++) begin
                    drive(0, 8'd0, 0, 1);
                    step();
                    check_out($sformatf("gap%0d_%0d", b, g), 1, 0, 0, 0, 0);
                end
            end
        end
        check_out("gap record", 0, 1, 8'd6, 8'd3, 1);
        drive(0, 8'd0, 0, 1); step(); check_out("gap idle", 1, 0, 0, 0, 0);

        // Reset while EMIT holds (3,6): record must vanish, never transfer.
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'd3, 0, 0);
            step();
        end
        drive(1, 8'd5, 0, 0); step(); check_out("rst emit", 0, 1, 8'd3, 8'd6, 0);
        drive(0, 8'd0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst emit cleared", 32'({o_in_ready, o_out_valid, o_out_val, o_out_len, o_out_last}),
              32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'd0, 0, 1);
            step();
            check_out($sformatf("rst quiet%0d", i), 1, 0, 0, 0, 0);
        end
        drive(1, 8'h11, 1, 1); step(); check_out("rst new stream", 0, 1, 8'h11, 8'd1, 1);
        drive(0, 8'd0, 0, 1); step(); check_out("rst new idle", 1, 0, 0, 0, 0);

        // Reset mid-RUN discards the open run of 1s.
        drive(1, 8'd1, 0, 1); step();
        drive(1, 8'd1, 0, 1); step();
        drive(0, 8'd0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, 8'd2, 1, 1); step(); check_out("rst run new", 0, 1, 8'd2, 8'd1, 1);
        drive(0, 8'd0, 0, 1); step(); check_out("rst run idle", 1, 0, 0, 0, 0);

        // 300 equal beats at LEN_W=8 split into 255 + 45.
        bq = {};
        for (int i = 0; i < 300; i++) bq.push_back(beat_t'{val: 8'h77, last: (i == 299)});
        eq = {};
        eq.push_back(rec_t'{val: 8'h77, len: 8'd255, last: 1'b0});
        eq.push_back(rec_t'{val: 8'h77, len: 8'd45,  last: 1'b1});
        run_stream(bq, eq, 0, 100, "split255");

        // LEN_W=2: seven 9s -> (9,3),(9,3),(9,1,last).
        sel = 1'b1;
        step();
        bq = {};
        for (int i = 0; i < 7; i++) bq.push_back(beat_t'{val: 8'd9, last: (i == 6)});
        eq = {};
        eq.push_back(rec_t'{val: 8'd9, len: 8'd3, last: 1'b0});
        eq.push_back(rec_t'{val: 8'd9, len: 8'd3, last: 1'b0});
        eq.push_back(rec_t'{val: 8'd9, len: 8'd1, last: 1'b1});
        run_stream(bq, eq, 0, 100, "split3");

        // Random streams on both instances against the reference model.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            drive(0, 8'd0, 0, 1);
            step();
            for (int n = 0; n < 40; n++) begin
                int len = $urandom_range(1, 20);
                bq = {};
                for (int k = 0; k < len; k++)
                    bq.push_back(beat_t'{val: 8'($urandom_range(0, 2)), last: (k == len - 1)});
                run_stream(bq, model(bq, (s == 1) ? 3 : 255), 30, 60,
                           $sformatf("rnd%0d_%0d", s, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_ctrl.md
RLE_CTRL -- requirements
Module: rle_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width.
REQ-002 SHALL have parameter LEN_W, default 8, run-length field width; max run length RUN_MAX = 2^LEN_W - 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  sample beat present.
REQ-006 SHALL have port in_val  input  DATA_W  sample value.
REQ-007 SHALL have port in_last  input  1  beat is the final sample of the stream.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle; a beat transfers when in_valid and in_ready are both 1.
REQ-009 SHALL have port out_valid  output  1  run record present.
REQ-010 SHALL have port out_val  output  DATA_W  value of the run.
REQ-011 SHALL have port out_len  output  LEN_W  run length, 1..RUN_MAX.
REQ-012 SHALL have port out_last  output  1  record is the final record of the stream.
REQ-013 SHALL have port out_ready  input  1  consumer accepts a record; a record transfers when out_valid and out_ready are both 1.

Function
REQ-014 SHALL implement states IDLE (no open run), RUN (open run held in cur_val/cur_len), EMIT (record presented, new beat pending), and EMIT_LAST (final record presented).
REQ-015 SHALL assert in_ready in IDLE and RUN only, and SHALL deassert out_valid in IDLE and RUN.
REQ-016 IDLE: an accepted beat SHALL load cur_val=in_val, cur_len=1, and go to RUN, or to EMIT_LAST if in_last=1.
REQ-017 RUN: an accepted beat with in_val==cur_val and cur_len<RUN_MAX SHALL increment cur_len and stay in RUN, or go to EMIT_LAST if in_last=1.
REQ-018 RUN: an accepted beat with in_val!=cur_val, or with cur_len==RUN_MAX, SHALL present record (cur_val, cur_len), latch the beat as pending (value, length 1, last flag), and go to EMIT.
REQ-019 EMIT: on record transfer, the pending beat SHALL become the open run; the next state SHALL be RUN, or EMIT_LAST if the pending last flag is set.
REQ-020 EMIT_LAST: SHALL present (cur_val, cur_len) with out_last=1; on transfer the next state SHALL be IDLE.
REQ-021 A record SHALL appear on out_valid in the cycle after the beat that closed it is accepted; it SHALL hold stable until transfer (no drop, no change while out_ready=0).
REQ-022 cur_len SHALL never wrap; a run longer than RUN_MAX SHALL split into a RUN_MAX record followed by the remainder.
REQ-023 in_valid=0 in RUN SHALL hold the open run indefinitely; no record is emitted without in_last or a closing beat.
REQ-024 out_last SHALL be 0 on every record other than the EMIT_LAST record.

Reset
REQ-025 rst=1 at a rising edge SHALL force state=IDLE, cur_val=0, cur_len=0, pending cleared, out_valid=0, out_val=0, out_len=0, out_last=0; in_ready=1 the cycle after reset deasserts.
REQ-026 Reset mid-run or mid-EMIT SHALL discard the open run and the pending beat without emitting any record.

Structure
REQ-027 Package rle_pkg SHALL hold the state enum type and default DATA_W/LEN_W constants.
REQ-028 The run-length datapath (compare, saturating increment, load) SHALL be a sub-module run_counter; rle_ctrl SHALL hold the FSM and handshake logic.

Verification
REQ-029 Beats 5,5,5,7(last), out_ready=1 -> records (5,3,last=0), then (7,1,last=1); state returns to IDLE.
REQ-030 LEN_W=2, beats 9 x7 with last on the 7th -> records (9,3),(9,3),(9,1,last=1).
REQ-031 Beats 4,8 with out_ready=0 for 5 cycles after the mismatch -> out_valid held with (4,1) unchanged, in_ready=0 throughout, then (8,...) continues after the transfer.
REQ-032 Single beat 0x2A with in_last in IDLE -> one record (0x2A,1,last=1) the next cycle.
REQ-033 rst pulsed while in EMIT holding (3,6) -> out_valid=0 the next cycle, no record ever emitted for value 3, in_ready=1.
REQ-034 in_valid gaps of 3 cycles between equal beats 6,6,6(last) -> single record (6,3,last=1).
